// File: rtl/keypad_scan_ctrl_if.sv
// Key handshake bundle between the keypad scan controller and the key decoder.
// The master side is the scan controller. It drives the code, the valid flag
// and the sticky overrun flag. The slave side returns the one-cycle acknowledge.
interface keypad_scan_ctrl_if;
  logic [3:0] KEYCODE;
  logic       KEYVALID;
  logic       OVERRUN;
  logic       KEYACK;

  modport master (
    output KEYCODE,
    output KEYVALID,
    output OVERRUN,
    input  KEYACK
  );

  modport slave (
    input  KEYCODE,
    input  KEYVALID,
    input  OVERRUN,
    output KEYACK
  );
endinterface

// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix keypad scan controller.
// A slow scan tick is derived from CLKIN as a one-cycle enable. An active-low
// row strobe walks the matrix, and presses and releases are debounced over
// DEBOUNCE ticks. Each accepted key is presented as code row*4+column on the
// valid/acknowledge handshake.
// Optional feature: define KEYPAD_REPEAT_EN to re-emit a held key every
// REPEAT ticks. When the macro is undefined, no repeat counter is built.
module keypad_scan_ctrl #(
  parameter int DIV      = 50000,
  parameter int DEBOUNCE = 4,
  parameter int REPEAT   = 32
) (
  input  logic               CLKIN,
  input  logic               ACLR_L,
  input  logic [3:0]         COL,
  output logic [3:0]         ROW_L,
  keypad_scan_ctrl_if.master key_if
);

  if (DIV < 2 || DEBOUNCE < 1 || DEBOUNCE > 15 || REPEAT < 1) begin : g_bad_cfg
    $error("keypad_scan_ctrl: parameter out of range");
  end

  localparam int             TW        = $clog2(DIV);
  localparam logic [TW-1:0]  TICK_LAST = TW'(DIV - 1);
  localparam logic [3:0]     DEB_LAST  = 4'(DEBOUNCE);

  typedef enum logic [1:0] {SCAN, DEB, HELD, REL} state_e;

  logic [3:0]    col_meta_q, col_sync_q;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic          tick;
  state_e        state_q, state_d;
  logic [3:0]    row_l_q, row_l_d;
  logic [1:0]    row_sel_q, row_sel_d;
  logic [1:0]    cap_row_q, cap_row_d;
  logic [1:0]    cap_col_q, cap_col_d;
  logic [3:0]    deb_cnt_q, deb_cnt_d;
  logic [1:0]    low_col;
  logic          key_low;
  logic          emit;
  logic [3:0]    emit_code;
  logic [3:0]    keycode_q, keycode_d;
  logic          keyvalid_q, keyvalid_d;
  logic          overrun_q, overrun_d;

`ifdef KEYPAD_REPEAT_EN
  localparam int            RW       = $clog2(REPEAT + 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT);
  logic [RW-1:0] rep_cnt_q, rep_cnt_d;
`endif

  // Two-flop synchronizer; the columns are asynchronous and idle high
  always_ff @(posedge CLKIN or negedge ACLR_L) begin
    if (!ACLR_L) begin
      col_meta_q <= 4'hF;
      col_sync_q <= 4'hF;
    end else begin
      col_meta_q <= COL;
      col_sync_q <= col_meta_q;
    end
  end

  // Free-running scan divider producing a one-cycle tick enable
  always_comb begin
    tick       = (tick_cnt_q == TICK_LAST);
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
  end

  // Lowest-index column pulled low, and the level of the captured column
  always_comb begin
    low_col = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!col_sync_q[i]) low_col = 2'(i);
    end
    key_low = ~col_sync_q[cap_col_q];
  end

  // Scan/debounce FSM next state; all transitions happen on the tick only
  always_comb begin
    state_d   = state_q;
    row_l_d   = row_l_q;
    row_sel_d = row_sel_q;
    cap_row_d = cap_row_q;
    cap_col_d = cap_col_q;
    deb_cnt_d = deb_cnt_q;
    emit      = 1'b0;
    emit_code = {cap_row_q, cap_col_q};
`ifdef KEYPAD_REPEAT_EN
    rep_cnt_d = rep_cnt_q;
`endif
    if (tick) begin
      case (state_q)
        SCAN: begin
          if (col_sync_q == 4'hF) begin
            row_l_d   = {row_l_q[2:0], row_l_q[3]};
            row_sel_d = row_sel_q + 2'd1;
          end else begin
            cap_row_d = row_sel_q;
            cap_col_d = low_col;
            deb_cnt_d = 4'd1;
            emit_code = {row_sel_q, low_col};
            if (DEB_LAST == 4'd1) begin
              emit    = 1'b1;
              state_d = HELD;
            end else begin
              state_d = DEB;
            end
          end
        end
        DEB: begin
          if (key_low) begin
            deb_cnt_d = deb_cnt_q + 4'd1;
            if (deb_cnt_q + 4'd1 == DEB_LAST) begin
              emit    = 1'b1;
              state_d = HELD;
            end
          end else begin
            deb_cnt_d = 4'd0;
            row_l_d   = {row_l_q[2:0], row_l_q[3]};
            row_sel_d = row_sel_q + 2'd1;
            state_d   = SCAN;
          end
        end
        HELD: begin
          if (!key_low) begin
            deb_cnt_d = 4'd1;
            if (DEB_LAST == 4'd1) begin
              row_l_d   = {row_l_q[2:0], row_l_q[3]};
              row_sel_d = row_sel_q + 2'd1;
              state_d   = SCAN;
            end else begin
              state_d = REL;
            end
          end
        end
        REL: begin
          if (!key_low) begin
            deb_cnt_d = deb_cnt_q + 4'd1;
            if (deb_cnt_q + 4'd1 == DEB_LAST) begin
              row_l_d   = {row_l_q[2:0], row_l_q[3]};
              row_sel_d = row_sel_q + 2'd1;
              state_d   = SCAN;
            end
          end else begin
            state_d = HELD;
          end
        end
        default: state_d = SCAN;
      endcase
    end
`ifdef KEYPAD_REPEAT_EN
    if (state_d != HELD) begin
      rep_cnt_d = '0;
    end else if (tick && state_q == HELD) begin
      if (rep_cnt_q + 1'b1 == REP_LAST) begin
        rep_cnt_d = '0;
        emit      = 1'b1;
      end else begin
        rep_cnt_d = rep_cnt_q + 1'b1;
      end
    end
`endif
  end

  // Handshake: load a new code, drop it as an overrun, or clear on acknowledge
  always_comb begin
    keycode_d  = keycode_q;
    keyvalid_d = keyvalid_q;
    overrun_d  = overrun_q;
    if (emit) begin
      if (!keyvalid_q || key_if.KEYACK) begin
        keycode_d  = emit_code;
        keyvalid_d = 1'b1;
        if (keyvalid_q) overrun_d = 1'b0;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (key_if.KEYACK && keyvalid_q) begin
      keyvalid_d = 1'b0;
      overrun_d  = 1'b0;
    end
  end

  // State, scan and handshake registers
  always_ff @(posedge CLKIN or negedge ACLR_L) begin
    if (!ACLR_L) begin
      tick_cnt_q <= '0;
      state_q    <= SCAN;
      row_l_q    <= 4'b1110;
      row_sel_q  <= 2'd0;
      cap_row_q  <= 2'd0;
      cap_col_q  <= 2'd0;
      deb_cnt_q  <= 4'd0;
      keycode_q  <= 4'd0;
      keyvalid_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      state_q    <= state_d;
      row_l_q    <= row_l_d;
      row_sel_q  <= row_sel_d;
      cap_row_q  <= cap_row_d;
      cap_col_q  <= cap_col_d;
      deb_cnt_q  <= deb_cnt_d;
      keycode_q  <= keycode_d;
      keyvalid_q <= keyvalid_d;
      overrun_q  <= overrun_d;
    end
  end

`ifdef KEYPAD_REPEAT_EN
  // Auto-repeat tick counter, cleared whenever the key is not held
  always_ff @(posedge CLKIN or negedge ACLR_L) begin
    if (!ACLR_L) rep_cnt_q <= '0;
    else         rep_cnt_q <= rep_cnt_d;
  end
`endif

  assign ROW_L           = row_l_q;
  assign key_if.KEYCODE  = keycode_q;
  assign key_if.KEYVALID = keyvalid_q;
  assign key_if.OVERRUN  = overrun_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl with DIV=4, DEBOUNCE=3, REPEAT=2.
// A behavioural 4x4 matrix pulls a column low when its pressed key's row is strobed.
module tb_keypad_scan_ctrl;
  logic        clk = 1'b0;
  logic        aclr_l;
  logic [3:0]  col_model;
  logic [3:0]  row_l;
  logic [15:0] key_down;
  int          vec_count = 0;
  int          miss_count = 0;
  bit          seen;

  keypad_scan_ctrl_if key_if ();

  keypad_scan_ctrl #(.DIV(4), .DEBOUNCE(3), .REPEAT(2)) dut (
    .CLKIN  (clk),
    .ACLR_L (aclr_l),
    .COL    (col_model),
    .ROW_L  (row_l),
    .key_if (key_if.master)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Matrix model: a pressed key shorts its column to its row when that row is low
  always_comb begin
    col_model = 4'hF;
    for (int r = 0; r < 4; r++) begin
      if (!row_l[r]) begin
        for (int c = 0; c < 4; c++) begin
          if (key_down[r*4+c]) col_model[c] = 1'b0;
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_count++;
    if (got !== exp) begin
      miss_count++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input int key, input bit down);
    key_down[key] = down;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic waitValid(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      @(negedge clk);
      if (key_if.KEYVALID) ok = 1'b1;
    end
  endtask

  task automatic waitOverrun(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      @(negedge clk);
      if (key_if.OVERRUN) ok = 1'b1;
    end
  endtask

  // Returns at the first negedge on which the strobe has just moved onto target
  task automatic waitRowEntry(input logic [3:0] target, input int bound, output bit ok);
    bit left;
    left = (row_l != target);
    ok   = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      @(negedge clk);
      if (row_l != target) left = 1'b1;
      else if (left) ok = 1'b1;
    end
  endtask

  task automatic ackPulse();
    @(negedge clk);
    key_if.KEYACK = 1'b1;
    @(negedge clk);
    key_if.KEYACK = 1'b0;
  endtask

  initial begin
    logic [3:0] exp_rows [4];
    int gap;
    exp_rows[0] = 4'b1101;
    exp_rows[1] = 4'b1011;
    exp_rows[2] = 4'b0111;
    exp_rows[3] = 4'b1110;
    aclr_l        = 1'b0;
    key_if.KEYACK = 1'b0;
    key_down      = 16'h0;

    // Reset and free scanning
    waitCycles(3);
    aclr_l = 1'b1;
    checkOutput("rst_row", 32'(row_l), 32'h_e);
    checkOutput("rst_valid", 32'(key_if.KEYVALID), 32'h0);
    checkOutput("rst_overrun", 32'(key_if.OVERRUN), 32'h0);
    checkOutput("rst_code", 32'(key_if.KEYCODE), 32'h0);
    for (int i = 0; i < 4; i++) begin
      repeat (4) @(posedge clk);
      @(negedge clk);
      checkOutput($sformatf("scan_step%0d", i), 32'(row_l), 32'(exp_rows[i]));
    end

    // Clean press of row 2 column 1
    applyStimulus(9, 1'b1);
    waitValid(80, seen);
    checkOutput("clean_valid_seen", 32'(seen), 32'h1);
    checkOutput("clean_code", 32'(key_if.KEYCODE), 32'h9);
    waitCycles(40);
    checkOutput("clean_hold_valid", 32'(key_if.KEYVALID), 32'h1);
    checkOutput("clean_hold_code", 32'(key_if.KEYCODE), 32'h9);
`ifndef KEYPAD_REPEAT_EN
    checkOutput("clean_single_code", 32'(key_if.OVERRUN), 32'h0);
`endif
    applyStimulus(9, 1'b0);
    waitCycles(30);
    checkOutput("clean_unacked_valid", 32'(key_if.KEYVALID), 32'h1);
    ackPulse();
    checkOutput("clean_ack_valid", 32'(key_if.KEYVALID), 32'h0);
    waitCycles(40);
    checkOutput("clean_no_second", 32'(key_if.KEYVALID), 32'h0);

    // Press bounce: key 6 seen low on two ticks only
    waitRowEntry(4'b1101, 40, seen);
    checkOutput("bounce_row_align", 32'(seen), 32'h1);
    applyStimulus(6, 1'b1);
    repeat (6) @(posedge clk);
    @(negedge clk);
    applyStimulus(6, 1'b0);
    waitRowEntry(4'b1011, 20, seen);
    checkOutput("bounce_scan_resumes", 32'(seen), 32'h1);
    waitCycles(20);
    checkOutput("bounce_no_valid", 32'(key_if.KEYVALID), 32'h0);

    // Release bounce shorter than the debounce window
    applyStimulus(6, 1'b1);
    waitValid(80, seen);
    checkOutput("relb_valid_seen", 32'(seen), 32'h1);
    checkOutput("relb_code", 32'(key_if.KEYCODE), 32'h6);
    ackPulse();
    checkOutput("relb_ack_valid", 32'(key_if.KEYVALID), 32'h0);
    applyStimulus(6, 1'b0);
    waitCycles(6);
    applyStimulus(6, 1'b1);
    waitCycles(20);
`ifndef KEYPAD_REPEAT_EN
    checkOutput("relb_no_second", 32'(key_if.KEYVALID), 32'h0);
`endif
    applyStimulus(6, 1'b0);
    waitCycles(40);
    if (key_if.KEYVALID) ackPulse();
    checkOutput("relb_idle_valid", 32'(key_if.KEYVALID), 32'h0);

    // Overrun: two codes without acknowledge
    applyStimulus(0, 1'b1);
    waitValid(80, seen);
    checkOutput("ovr_first_seen", 32'(seen), 32'h1);
    applyStimulus(0, 1'b0);
    waitCycles(30);
    applyStimulus(15, 1'b1);
    waitOverrun(100, seen);
    checkOutput("ovr_flag", 32'(key_if.OVERRUN), 32'h1);
    checkOutput("ovr_code_kept", 32'(key_if.KEYCODE), 32'h0);
    checkOutput("ovr_valid", 32'(key_if.KEYVALID), 32'h1);
    applyStimulus(15, 1'b0);
    waitCycles(30);
    ackPulse();
    checkOutput("ovr_ack_valid", 32'(key_if.KEYVALID), 32'h0);
    checkOutput("ovr_ack_overrun", 32'(key_if.OVERRUN), 32'h0);

    // Acknowledge coincident with the second emit
    applyStimulus(0, 1'b1);
    waitValid(80, seen);
    checkOutput("sim_first_code", 32'(key_if.KEYCODE), 32'h0);
    applyStimulus(0, 1'b0);
    waitCycles(40);
    waitRowEntry(4'b0111, 40, seen);
    checkOutput("sim_row_align", 32'(seen), 32'h1);
    applyStimulus(15, 1'b1);
    repeat (11) @(posedge clk);
    @(negedge clk);
    key_if.KEYACK = 1'b1;
    @(negedge clk);
    key_if.KEYACK = 1'b0;
    checkOutput("sim_code", 32'(key_if.KEYCODE), 32'hf);
    checkOutput("sim_valid", 32'(key_if.KEYVALID), 32'h1);
    checkOutput("sim_overrun", 32'(key_if.OVERRUN), 32'h0);
    applyStimulus(15, 1'b0);
    waitCycles(40);

    // Reset while debouncing, with a code still pending
    waitRowEntry(4'b1101, 40, seen);
    applyStimulus(5, 1'b1);
    repeat (6) @(posedge clk);
    @(negedge clk);
    aclr_l = 1'b0;
    #1;
    checkOutput("mid_rst_row", 32'(row_l), 32'he);
    checkOutput("mid_rst_code", 32'(key_if.KEYCODE), 32'h0);
    checkOutput("mid_rst_valid", 32'(key_if.KEYVALID), 32'h0);
    checkOutput("mid_rst_overrun", 32'(key_if.OVERRUN), 32'h0);
    applyStimulus(5, 1'b0);
    waitCycles(2);
    aclr_l = 1'b1;
    waitCycles(60);
    checkOutput("mid_rst_no_code", 32'(key_if.KEYVALID), 32'h0);

`ifdef KEYPAD_REPEAT_EN
    // Auto-repeat: a new code every two ticks while key 5 is held
    applyStimulus(5, 1'b1);
    waitValid(80, seen);
    checkOutput("rep_first_seen", 32'(seen), 32'h1);
    checkOutput("rep_first_code", 32'(key_if.KEYCODE), 32'h5);
    for (int k = 0; k < 3; k++) begin
      key_if.KEYACK = 1'b1;
      @(negedge clk);
      key_if.KEYACK = 1'b0;
      gap = 0;
      while (!key_if.KEYVALID && gap < 50) begin
        @(negedge clk);
        gap++;
      end
      checkOutput($sformatf("rep_gap%0d", k), 32'(gap), 32'd7);
      checkOutput($sformatf("rep_code%0d", k), 32'(key_if.KEYCODE), 32'h5);
    end
    applyStimulus(5, 1'b0);
    waitCycles(40);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule

// File: doc/keypad_scan_ctrl.md
# keypad_scan_ctrl

Scan controller for the 4x4 matrix keypad of the keyboard reader. It derives a slow scan tick internally from CLKIN as a one-cycle enable, never as a derived clock, and walks an active-low row strobe across the matrix. Each press is debounced and presented once on a valid/acknowledge handshake to the downstream decoder. Key codes are row*4+column.

## Interface
- DIV, 50000, CLKIN cycles per scan tick (>= 2)
- DEBOUNCE, 4, consecutive stable ticks required for press and for release (1..15)
- REPEAT, 32, ticks between auto-repeat codes (used only with KEYPAD_REPEAT_EN)

- CLKIN  in  1  system clock; all state on rising edge
- ACLR_L  in  1  asynchronous active-low clear
- COL  in  4  keypad columns, active-low, externally pulled up, asynchronous
- KEYACK  in  1  one-cycle acknowledge from consumer
- ROW_L  out  4  row strobe, exactly one bit low
- KEYCODE  out  4  code of last accepted key
- KEYVALID  out  1  KEYCODE holds an unacknowledged code
- OVERRUN  out  1  sticky; a code was dropped while KEYVALID=1

## Operation
- COL passes through a 2-flop synchronizer; all decisions use the synchronized value COLS.
- Tick counter runs 0..DIV-1, width ceil(log2(DIV)); TICK=1 for the one cycle where count==DIV-1, then wraps to 0.
- States: SCAN, DEB, HELD, REL. All transitions occur only on TICK.
- SCAN: if COLS==4'hF, rotate ROW_L left (1110->1101->1011->0111->1110). Otherwise capture row index R and lowest-index low column C, set cnt=1, go DEB. ROW_L holds.
- DEB: if COLS[C]==0, cnt++. When cnt reaches DEBOUNCE, emit code {R,C} and go HELD. If COLS[C]==1, rotate ROW_L and go SCAN with no code. If DEBOUNCE==1, the code is emitted on the capture tick and DEB is skipped.
- HELD: if COLS[C]==1, set cnt=1 and go REL. Other columns going low are ignored.
- REL: if COLS[C]==1, cnt++. At cnt==DEBOUNCE, rotate ROW_L and go SCAN. If COLS[C]==0, return to HELD.
- Emit with KEYVALID=0: KEYCODE<=code, KEYVALID<=1.
- Emit with KEYVALID=1 and no KEYACK that cycle: code is dropped, KEYCODE unchanged, OVERRUN<=1.
- Emit and KEYACK in the same cycle: new code loads, KEYVALID stays 1, no overrun.
- KEYACK while KEYVALID=1 and no emit: KEYVALID<=0, OVERRUN<=0.
- KEYACK while KEYVALID=0 is ignored.

## Timing
- Reset values: ROW_L=4'b1110, KEYCODE=0, KEYVALID=0, OVERRUN=0, state SCAN, tick count 0, synchronizer 4'hF, cnt=0.
- ACLR_L low mid-operation aborts any state immediately, including a pending code.
- After a row changes, that row is not sampled until the next TICK, giving one full tick of settling.
- COL change to COLS: 2 cycles.
- KEYCODE and KEYVALID update in the cycle after the emitting TICK.
- Best-case press latency: synchronizer + wait for the row's tick + (DEBOUNCE-1) further ticks + 1 cycle.

## Configuration
- KEYPAD_REPEAT_EN defined:
  - In HELD, a repeat counter reloads on entry and counts ticks.
  - Every REPEAT ticks it re-emits the same code, following the same emit and overrun rules.
  - Leaving HELD clears the counter.
- KEYPAD_REPEAT_EN undefined: exactly one code per debounced press; REPEAT is unused, and no repeat counter is synthesized.

## Test plan
Bench uses DIV=4, DEBOUNCE=3, REPEAT=2.
- Reset: hold ACLR_L low, release with COL=4'hF.
  - Required: ROW_L=1110 and KEYVALID=0, OVERRUN=0.
  - Over 16 cycles, ROW_L steps 1101, 1011, 0111, 1110 every 4 cycles.
- Clean press: model row 2, column 1 (COL[1] low only while ROW_L[2]=0), held 40 cycles.
  - Required: KEYCODE=4'h9 and KEYVALID=1 until KEYACK pulses; exactly one code without the macro.
- Bounce: key low for only 2 ticks, then released.
  - Required: no KEYVALID and scanning resumes.
  - Repeat with release bounce shorter than 3 ticks: no second code.
- Overrun: two distinct presses (codes 4'h0, 4'hF) with no KEYACK.
  - Required: KEYCODE=4'h0 and OVERRUN=1.
  - After KEYACK: KEYVALID=0, OVERRUN=0.
- Simultaneous: assert KEYACK in the exact cycle of the second emit.
  - Required: KEYCODE=4'hF, KEYVALID=1, OVERRUN=0.
- Mid-operation reset, then macro check:
  - Drop ACLR_L while in DEB. Required: all reset values at once, and no code after release.
  - With KEYPAD_REPEAT_EN, hold code 4'h5 and ack each code. Required: a new KEYVALID rise every 2 ticks.
